// File: rtl/sqrt_bus_master.sv
// Drives a memory-mapped sqrt peripheral: write operand, pulse init, poll done, read result.
// Latency 8+POLL_GAP cycles plus POLL_GAP+2 per extra poll; the response is held until rsp_ready.
module sqrt_bus_master #(
    parameter int TIMEOUT  = 1023,
    parameter int POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_operand,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_timeout,
    output logic        cs,
    output logic [4:0]  addr,
    output logic        rd,
    output logic        wr,
    output logic [15:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [PW-1:0] TIMEOUT_W = PW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    localparam logic [4:0] ADDR_OPERAND = 5'h04;
    localparam logic [4:0] ADDR_INIT    = 5'h0C;
    localparam logic [4:0] ADDR_RESULT  = 5'h10;
    localparam logic [4:0] ADDR_DONE    = 5'h14;

    typedef enum logic [3:0] {
        IDLE, WR_OP, WR_CLR, WR_SET, GAP, POLL, CHK, RD_RES, CAP, WR_END, RESP
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     operand;
    logic [15:0]     result_q;
    logic [PW-1:0]   poll_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            timeout_flag;
    logic            poll_expired;
    logic            unused_rdata;

    assign unused_rdata = ^bus_rdata[31:16];
    assign poll_expired = (poll_cnt >= TIMEOUT_W);
    assign rsp_result   = result_q;
    assign rsp_timeout  = timeout_flag;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        cs        = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        addr      = 5'd0;
        bus_wdata = 16'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = WR_OP;
            end
            WR_OP: begin
                cs = 1'b1; wr = 1'b1; addr = ADDR_OPERAND; bus_wdata = operand;
                state_nxt = WR_CLR;
            end
            // Dropping init first guarantees the peripheral sees a rising edge.
            WR_CLR: begin
                cs = 1'b1; wr = 1'b1; addr = ADDR_INIT;
                state_nxt = WR_SET;
            end
            WR_SET: begin
                cs = 1'b1; wr = 1'b1; addr = ADDR_INIT; bus_wdata = 16'd1;
                state_nxt = (POLL_GAP == 0) ? POLL : GAP;
            end
            GAP: begin
                if (gap_cnt >= GAP_LAST) state_nxt = POLL;
            end
            POLL: begin
                cs = 1'b1; rd = 1'b1; addr = ADDR_DONE;
                state_nxt = CHK;
            end
            CHK: begin
                if (bus_rdata[0])      state_nxt = RD_RES;
                else if (poll_expired) state_nxt = WR_END;
                else                   state_nxt = (POLL_GAP == 0) ? POLL : GAP;
            end
            RD_RES: begin
                cs = 1'b1; rd = 1'b1; addr = ADDR_RESULT;
                state_nxt = CAP;
            end
            CAP: state_nxt = WR_END;
            WR_END: begin
                cs = 1'b1; wr = 1'b1; addr = ADDR_INIT;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            operand      <= 16'd0;
            result_q     <= 16'd0;
            poll_cnt     <= '0;
            gap_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                operand      <= req_operand;
                result_q     <= 16'd0;
                timeout_flag <= 1'b0;
            end
            // Saturates at TIMEOUT so a long wait can never wrap back below it.
            if (state == WR_SET)
                poll_cnt <= '0;
            else if (state == POLL && poll_cnt < TIMEOUT_W)
                poll_cnt <= poll_cnt + 1'b1;
            if (state == GAP && state_nxt == GAP)
                gap_cnt <= gap_cnt + 1'b1;
            else
                gap_cnt <= '0;
            if (state == CHK && !bus_rdata[0] && poll_expired)
                timeout_flag <= 1'b1;
            if (state == CAP)
                result_q <= bus_rdata[15:0];
        end
    end

endmodule

// File: tb/tb_sqrt_bus_master.sv
// Bench for sqrt_bus_master: peripheral model, bus-access scoreboard and response scoreboard.
module tb_sqrt_bus_master;

    localparam int G  = 4;
    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_operand = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic        rsp_timeout;
    logic        cs, rd, wr;
    logic [4:0]  addr;
    logic [15:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;

    sqrt_bus_master #(.TIMEOUT(TO), .POLL_GAP(G)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_poll = -1;

    logic [21:0] bus_q[$];
    logic [16:0] rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] isqrt(input logic [15:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return 16'(r);
    endfunction

    // Peripheral model: accesses are latched mid-cycle and applied on the next rising edge.
    logic [15:0] p_operand = 16'd0;
    logic        p_init = 1'b0;
    int          p_polls = 0;
    int          p_done_after = 0;
    logic        pend_rd = 1'b0, pend_wr = 1'b0;
    logic [4:0]  pend_addr = 5'd0;
    logic [15:0] pend_wdata = 16'd0;

    always @(posedge clk) begin
        if (pend_wr) begin
            if (pend_addr == 5'h04) p_operand = pend_wdata;
            if (pend_addr == 5'h0C) begin
                if (pend_wdata[0] && !p_init) p_polls = 0;
                p_init = pend_wdata[0];
            end
        end
        if (pend_rd) begin
            if (pend_addr == 5'h14) begin
                p_polls++;
                bus_rdata <= {16'h5A5A, 15'd0, (p_done_after != 0 && p_polls >= p_done_after)};
            end else if (pend_addr == 5'h10) begin
                bus_rdata <= {16'hBEEF, isqrt(p_operand)};
            end else begin
                bus_rdata <= 32'd0;
            end
        end
    end

    // Bus monitor: protocol legality plus in-order comparison against expected accesses.
    always @(negedge clk) begin
        logic        have;
        logic [21:0] exp;
        pend_rd    = cs && rd;
        pend_wr    = cs && wr;
        pend_addr  = addr;
        pend_wdata = bus_wdata;
        chk("bus_proto", 32'((!cs && !rd && !wr && addr == 5'd0 && bus_wdata == 16'd0) ||
                             (cs && (rd ^ wr))), 32'd1);
        if (cs) begin
            have = (bus_q.size() > 0);
            exp  = have ? bus_q.pop_front() : 22'h3FFFFF;
            chk("bus_access", 32'({wr, addr, bus_wdata}), 32'(exp));
            if (rd && addr == 5'h14) begin
                if (last_poll >= 0) chk("poll_spacing", 32'(cyc - last_poll), 32'(G + 2));
                last_poll = cyc;
            end
        end
    end

    task automatic push_bus(input logic [15:0] op, input int polls, input logic to);
        bus_q.push_back({1'b1, 5'h04, op});
        bus_q.push_back({1'b1, 5'h0C, 16'd0});
        bus_q.push_back({1'b1, 5'h0C, 16'd1});
        for (int i = 0; i < polls; i++) bus_q.push_back({1'b0, 5'h14, 16'd0});
        if (!to) bus_q.push_back({1'b0, 5'h10, 16'd0});
        bus_q.push_back({1'b1, 5'h0C, 16'd0});
    endtask

    task automatic run_req(input logic [15:0] op, input int done_after, input int polls,
                           input logic [15:0] exp_res, input logic exp_to, input int hold);
        int k;
        int t0;
        logic [16:0] exp;
        p_done_after = done_after;
        last_poll = -1;
        push_bus(op, polls, exp_to);
        rsp_q.push_back({exp_to, exp_res});
        k = 0;
        while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_operand = op;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_operand = 16'h1234;
        t0 = cyc;
        rsp_ready = (hold == 0);
        k = 0;
        while (!rsp_valid && k < 200) begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            @(posedge clk); #1; k++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        chk("latency", 32'(cyc - t0),
            32'((exp_to ? 6 : 8) + G + (polls - 1) * (G + 2)));
        exp = (rsp_q.size() > 0) ? rsp_q.pop_front() : 17'h1FFFF;
        chk("rsp_data", 32'({rsp_timeout, rsp_result}), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            req_valid = (i == 3);
            req_operand = 16'h0999;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'({rsp_timeout, rsp_result}), 32'(exp));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_released", 32'(rsp_valid), 32'd0);
        chk("back_to_idle", 32'(req_ready), 32'd1);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_outputs", 32'({rsp_valid, rsp_timeout, cs, rd, wr}), 32'd0);
        chk("rst_result", 32'(rsp_result), 32'd0);
        chk("rst_bus", 32'({addr, bus_wdata}), 32'd0);
        reset = 1'b0;

        run_req(16'd144,   1, 1, 16'd12,  1'b0, 0);
        run_req(16'hFFFF,  3, 3, 16'd255, 1'b0, 0);
        run_req(16'd50,    0, TO, 16'd0,  1'b1, 0);
        run_req(16'd0,     1, 1, 16'd0,   1'b0, 0);
        run_req(16'd1000,  2, 2, 16'd31,  1'b0, 10);

        // Reset while waiting in GAP; req_valid in the same cycle must lose to reset.
        p_done_after = 0;
        bus_q.push_back({1'b1, 5'h04, 16'd77});
        bus_q.push_back({1'b1, 5'h0C, 16'd0});
        bus_q.push_back({1'b1, 5'h0C, 16'd1});
        req_valid = 1'b1;
        req_operand = 16'd77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_outputs", 32'({rsp_valid, rsp_timeout, cs, rd, wr}), 32'd0);
        chk("midrst_result", 32'(rsp_result), 32'd0);
        chk("midrst_bus_q", 32'(bus_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("midrst_quiet", 32'({req_ready, cs}), 32'b10);

        run_req(16'd16, 1, 1, 16'd4, 1'b0, 0);
        run_req(16'd81, 2, 2, 16'd9, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
